// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI transmitter: line states, bus messages, FSM states.
package mesi_pkg;

   localparam logic [1:0] ST_M = 2'b00;
   localparam logic [1:0] ST_E = 2'b01;
   localparam logic [1:0] ST_S = 2'b10;
   localparam logic [1:0] ST_I = 2'b11;

   localparam logic [1:0] MSG_RH = 2'b00;
   localparam logic [1:0] MSG_RM = 2'b01;
   localparam logic [1:0] MSG_WH = 2'b10;
   localparam logic [1:0] MSG_WM = 2'b11;

   localparam logic [1:0] FSM_IDLE = 2'd0;
   localparam logic [1:0] FSM_EVAL = 2'd1;
   localparam logic [1:0] FSM_BUS  = 2'd2;
   localparam logic [1:0] FSM_DONE = 2'd3;

endpackage

// File: rtl/mesi_transmissor_if.sv
// CPU request, bus broadcast and snoop-update signals of the MESI transmitter.
interface mesi_transmissor_if #(
   parameter int IDX_W = 2,
   parameter int TAG_W = 8
);
   logic             cpu_req;
   logic             cpu_we;
   logic [IDX_W-1:0] cpu_idx;
   logic [TAG_W-1:0] cpu_tag;
   logic             cpu_ready;
   logic             cpu_done;
   logic             cpu_hit;
   logic             bus_valid;
   logic             bus_ready;
   logic [1:0]       bus_msg;
   logic [IDX_W-1:0] bus_idx;
   logic [TAG_W-1:0] bus_tag;
   logic             bus_wb;
   logic             bus_shared;
   logic             snoop_valid;
   logic [IDX_W-1:0] snoop_idx;
   logic [TAG_W-1:0] snoop_tag;
   logic [1:0]       snoop_state;

   modport master (
      output cpu_req, cpu_we, cpu_idx, cpu_tag, bus_ready, bus_shared,
             snoop_valid, snoop_idx, snoop_tag, snoop_state,
      input  cpu_ready, cpu_done, cpu_hit, bus_valid, bus_msg, bus_idx,
             bus_tag, bus_wb
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_idx, cpu_tag, bus_ready, bus_shared,
             snoop_valid, snoop_idx, snoop_tag, snoop_state,
      output cpu_ready, cpu_done, cpu_hit, bus_valid, bus_msg, bus_idx,
             bus_tag, bus_wb
   );
endinterface

// File: rtl/mesi_line_array.sv
// Per-line MESI state and tag storage; local writes take priority over snoop updates.
module mesi_line_array
   import mesi_pkg::*;
#(
   parameter int NLINES = 4,
   parameter int IDX_W  = 2,
   parameter int TAG_W  = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [1:0]            rd_state,
   output logic [TAG_W-1:0]      rd_tag,
   input  logic                  lw_en,
   input  logic [IDX_W-1:0]      lw_idx,
   input  logic [1:0]            lw_state,
   input  logic [TAG_W-1:0]      lw_tag,
   input  logic                  sn_en,
   input  logic [IDX_W-1:0]      sn_idx,
   input  logic [TAG_W-1:0]      sn_tag,
   input  logic [1:0]            sn_state,
   output logic [2*NLINES-1:0]   line_state
);

   logic [NLINES-1:0][1:0]       st_q, st_d;
   logic [NLINES-1:0][TAG_W-1:0] tg_q, tg_d;

   assign rd_state   = st_q[rd_idx];
   assign rd_tag     = tg_q[rd_idx];
   assign line_state = st_q;

   // The local write is applied last so it overrides a snoop to the same line.
   always_comb begin
      st_d = st_q;
      tg_d = tg_q;
      if (sn_en && (st_q[sn_idx] != ST_I) && (tg_q[sn_idx] == sn_tag)) begin
         st_d[sn_idx] = sn_state;
      end
      if (lw_en) begin
         st_d[lw_idx] = lw_state;
         tg_d[lw_idx] = lw_tag;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         st_q <= '1;
         tg_q <= '0;
      end else begin
         st_q <= st_d;
         tg_q <= tg_d;
      end
   end

endmodule

// File: rtl/mesi_transmissor.sv
// Local-processor MESI controller: hit/miss evaluation, bus broadcast, snoop merge.
module mesi_transmissor
   import mesi_pkg::*;
#(
   parameter int NLINES = 4,
   parameter int IDX_W  = 2,
   parameter int TAG_W  = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   mesi_transmissor_if.slave   bus_if,
   output logic [2*NLINES-1:0] line_state
);

   logic [1:0]       fsm_q, fsm_d;
   logic             we_q, we_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             hit_q, hit_d;
   logic [1:0]       msg_q, msg_d;
   logic             wb_q, wb_d;

   logic [1:0]       rd_state;
   logic [TAG_W-1:0] rd_tag;
   logic             lw_en;
   logic [1:0]       lw_state;
   logic             hit;

   mesi_line_array #(.NLINES(NLINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_lines (
      .clock      (clock),
      .reset_n    (reset_n),
      .rd_idx     (idx_q),
      .rd_state   (rd_state),
      .rd_tag     (rd_tag),
      .lw_en      (lw_en),
      .lw_idx     (idx_q),
      .lw_state   (lw_state),
      .lw_tag     (tag_q),
      .sn_en      (bus_if.snoop_valid),
      .sn_idx     (bus_if.snoop_idx),
      .sn_tag     (bus_if.snoop_tag),
      .sn_state   (bus_if.snoop_state),
      .line_state (line_state)
   );

   assign hit = (rd_state != ST_I) && (rd_tag == tag_q);

   always_comb begin
      fsm_d    = fsm_q;
      we_d     = we_q;
      idx_d    = idx_q;
      tag_d    = tag_q;
      hit_d    = hit_q;
      msg_d    = msg_q;
      wb_d     = wb_q;
      lw_en    = 1'b0;
      lw_state = ST_M;
      case (fsm_q)
         FSM_IDLE: begin
            if (bus_if.cpu_req) begin
               we_d  = bus_if.cpu_we;
               idx_d = bus_if.cpu_idx;
               tag_d = bus_if.cpu_tag;
               fsm_d = FSM_EVAL;
            end
         end
         FSM_EVAL: begin
            hit_d = hit;
            if (hit && !(we_q && (rd_state == ST_S))) begin
               // Read hits leave the line alone; write hits in E/M land in M.
               lw_en = we_q;
               fsm_d = FSM_DONE;
            end else begin
               msg_d = hit ? MSG_WH : (we_q ? MSG_WM : MSG_RM);
               wb_d  = !hit && (rd_state == ST_M);
               fsm_d = FSM_BUS;
            end
         end
         FSM_BUS: begin
            if (bus_if.bus_ready) begin
               lw_en = 1'b1;
               if (msg_q == MSG_RM) lw_state = bus_if.bus_shared ? ST_S : ST_E;
               fsm_d = FSM_DONE;
            end
         end
         default: fsm_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q <= FSM_IDLE;
         we_q  <= 1'b0;
         idx_q <= '0;
         tag_q <= '0;
         hit_q <= 1'b0;
         msg_q <= MSG_RH;
         wb_q  <= 1'b0;
      end else begin
         fsm_q <= fsm_d;
         we_q  <= we_d;
         idx_q <= idx_d;
         tag_q <= tag_d;
         hit_q <= hit_d;
         msg_q <= msg_d;
         wb_q  <= wb_d;
      end
   end

   assign bus_if.cpu_ready = (fsm_q == FSM_IDLE);
   assign bus_if.cpu_done  = (fsm_q == FSM_DONE);
   assign bus_if.cpu_hit   = (fsm_q == FSM_DONE) && hit_q;
   assign bus_if.bus_valid = (fsm_q == FSM_BUS);
   assign bus_if.bus_msg   = msg_q;
   assign bus_if.bus_idx   = idx_q;
   assign bus_if.bus_tag   = tag_q;
   assign bus_if.bus_wb    = wb_q;

endmodule

// File: tb/tb_mesi_transmissor.sv
// Randomized and directed bench for mesi_transmissor against a protocol-level cache model.
module tb_mesi_transmissor;

   logic       clock;
   logic       reset_n;
   logic [7:0] line_state;
   int         checks;
   int         failures;

   logic [1:0] mst [4];
   logic [7:0] mtg [4];

   mesi_transmissor_if #(.IDX_W(2), .TAG_W(8)) ifc ();

   mesi_transmissor #(.NLINES(4), .IDX_W(2), .TAG_W(8)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .bus_if     (ifc),
      .line_state (line_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] model_pack();
      logic [7:0] v;
      for (int i = 0; i < 4; i++) v[2*i +: 2] = mst[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mst[i] = 2'b11;
         mtg[i] = 8'h00;
      end
   endtask

   task automatic model_snoop(input logic [1:0] idx, input logic [7:0] tag, input logic [1:0] st);
      if (mst[idx] != 2'b11 && mtg[idx] == tag) mst[idx] = st;
   endtask

   task automatic run_req(input logic we, input logic [1:0] idx, input logic [7:0] tag,
                          input logic shared, input int delay);
      logic       exp_hit, exp_bus, exp_wb, done, hit_seen;
      logic [1:0] exp_msg, new_st;
      int         lat, nvalid, waitc;
      exp_hit = (mst[idx] != 2'b11) && (mtg[idx] == tag);
      exp_bus = !(exp_hit && (!we || mst[idx] != 2'b10));
      exp_wb  = !exp_hit && (mst[idx] == 2'b00);
      exp_msg = !exp_hit ? (we ? 2'b11 : 2'b01) : 2'b10;
      new_st  = we ? 2'b00 : (exp_hit ? mst[idx] : (shared ? 2'b10 : 2'b01));
      waitc = 0;
      @(negedge clock);
      while (!ifc.cpu_ready && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      checks++;
      if (ifc.cpu_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_wait: cpu_ready=%b required 1", ifc.cpu_ready);
      end
      ifc.cpu_req = 1'b1; ifc.cpu_we = we; ifc.cpu_idx = idx; ifc.cpu_tag = tag;
      ifc.bus_shared = shared; ifc.bus_ready = 1'b0;
      @(posedge clock); #1;
      ifc.cpu_req = 1'b0; ifc.cpu_we = $urandom; ifc.cpu_idx = $urandom; ifc.cpu_tag = $urandom;
      done = 0; hit_seen = 0; lat = 0; nvalid = 0;
      while (!done && lat < 40) begin
         @(negedge clock);
         lat++;
         if (lat == 1) begin
            checks++;
            if (ifc.cpu_ready !== 1'b0 || ifc.bus_valid !== 1'b0 || ifc.cpu_done !== 1'b0) begin
               failures++;
               $display("FAIL eval_cycle: ready=%b valid=%b done=%b required 0 0 0",
                        ifc.cpu_ready, ifc.bus_valid, ifc.cpu_done);
            end
         end
         if (ifc.bus_valid) begin
            checks++;
            if (ifc.bus_msg !== exp_msg || ifc.bus_idx !== idx || ifc.bus_tag !== tag || ifc.bus_wb !== exp_wb) begin
               failures++;
               $display("FAIL bus_fields: msg=%b idx=%0d tag=%h wb=%b required msg=%b idx=%0d tag=%h wb=%b",
                        ifc.bus_msg, ifc.bus_idx, ifc.bus_tag, ifc.bus_wb, exp_msg, idx, tag, exp_wb);
            end
            ifc.bus_ready = (nvalid >= delay);
            nvalid++;
         end
         if (ifc.cpu_done) begin
            done = 1;
            hit_seen = ifc.cpu_hit;
         end
      end
      ifc.bus_ready = 1'b0;
      mst[idx] = new_st;
      mtg[idx] = tag;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL done_timeout: cpu_done never seen within %0d cycles", lat);
      end
      checks++;
      if (lat != (exp_bus ? 3 + delay : 2) || nvalid != (exp_bus ? delay + 1 : 0)) begin
         failures++;
         $display("FAIL latency: done_at=%0d valid_cycles=%0d required %0d %0d",
                  lat, nvalid, exp_bus ? 3 + delay : 2, exp_bus ? delay + 1 : 0);
      end
      checks++;
      if (hit_seen !== exp_hit) begin
         failures++;
         $display("FAIL cpu_hit: got %b required %b", hit_seen, exp_hit);
      end
      checks++;
      if (line_state !== model_pack()) begin
         failures++;
         $display("FAIL line_state_after_req: got %b required %b", line_state, model_pack());
      end
      @(negedge clock);
      checks++;
      if (ifc.cpu_done !== 1'b0 || ifc.cpu_ready !== 1'b1) begin
         failures++;
         $display("FAIL done_pulse: done=%b ready=%b required 0 1", ifc.cpu_done, ifc.cpu_ready);
      end
   endtask

   task automatic do_snoop(input logic [1:0] idx, input logic [7:0] tag, input logic [1:0] st);
      @(negedge clock);
      ifc.snoop_valid = 1'b1; ifc.snoop_idx = idx; ifc.snoop_tag = tag; ifc.snoop_state = st;
      @(posedge clock); #1;
      ifc.snoop_valid = 1'b0;
      model_snoop(idx, tag, st);
      @(negedge clock);
      checks++;
      if (line_state !== model_pack()) begin
         failures++;
         $display("FAIL snoop idx=%0d tag=%h st=%b: got %b required %b",
                  idx, tag, st, line_state, model_pack());
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      model_reset();
      checks++;
      if (line_state !== 8'hFF || ifc.cpu_done !== 1'b0 || ifc.cpu_hit !== 1'b0 ||
          ifc.bus_valid !== 1'b0 || ifc.bus_wb !== 1'b0 || ifc.bus_msg !== 2'b00 ||
          ifc.bus_idx !== 2'd0 || ifc.bus_tag !== 8'h00) begin
         failures++;
         $display("FAIL reset_state: lines=%b done=%b hit=%b valid=%b wb=%b msg=%b idx=%0d tag=%h required all-I and zeros",
                  line_state, ifc.cpu_done, ifc.cpu_hit, ifc.bus_valid, ifc.bus_wb,
                  ifc.bus_msg, ifc.bus_idx, ifc.bus_tag);
      end
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (ifc.cpu_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: cpu_ready=%b required 1", ifc.cpu_ready);
      end
   endtask

   task automatic test_directed_plan();
      run_req(1'b0, 2'd1, 8'h3A, 1'b0, 0);
      checks++;
      if (line_state[3:2] !== 2'b01) begin
         failures++;
         $display("FAIL read_miss_E: state1=%b required 01", line_state[3:2]);
      end
      run_req(1'b1, 2'd1, 8'h3A, 1'b0, 0);
      checks++;
      if (line_state[3:2] !== 2'b00) begin
         failures++;
         $display("FAIL write_hit_E_to_M: state1=%b required 00", line_state[3:2]);
      end
      run_req(1'b0, 2'd1, 8'h55, 1'b1, 0);
      checks++;
      if (line_state[3:2] !== 2'b10) begin
         failures++;
         $display("FAIL victim_wb_to_S: state1=%b required 10", line_state[3:2]);
      end
      run_req(1'b1, 2'd1, 8'h55, 1'b0, 3);
      checks++;
      if (line_state[3:2] !== 2'b00) begin
         failures++;
         $display("FAIL upgrade_to_M: state1=%b required 00", line_state[3:2]);
      end
   endtask

   task automatic test_snoop();
      do_snoop(2'd1, 8'h56, 2'b10);
      do_snoop(2'd1, 8'h55, 2'b11);
      checks++;
      if (line_state[3:2] !== 2'b11) begin
         failures++;
         $display("FAIL snoop_invalidate: state1=%b required 11", line_state[3:2]);
      end
      // Write hit on an E line with a same-line snoop landing on the EVAL->DONE edge.
      run_req(1'b0, 2'd2, 8'h10, 1'b0, 0);
      @(negedge clock);
      ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1; ifc.cpu_idx = 2'd2; ifc.cpu_tag = 8'h10;
      @(posedge clock); #1;
      ifc.cpu_req = 1'b0;
      ifc.snoop_valid = 1'b1; ifc.snoop_idx = 2'd2; ifc.snoop_tag = 8'h10; ifc.snoop_state = 2'b11;
      @(posedge clock); #1;
      ifc.snoop_valid = 1'b0;
      mst[2] = 2'b00;
      @(negedge clock);
      checks++;
      if (ifc.cpu_done !== 1'b1 || ifc.cpu_hit !== 1'b1 || line_state !== model_pack()) begin
         failures++;
         $display("FAIL local_beats_snoop: done=%b hit=%b lines=%b required 1 1 %b",
                  ifc.cpu_done, ifc.cpu_hit, line_state, model_pack());
      end
      @(negedge clock);
   endtask

   task automatic test_random();
      logic [7:0] tags [4];
      logic [1:0] idx;
      for (int n = 0; n < 60; n++) begin
         tags[0] = 8'h3A; tags[1] = 8'h55; tags[2] = 8'h10; tags[3] = 8'($urandom);
         idx = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            do_snoop(idx, ($urandom_range(0, 1) == 1) ? mtg[idx] : tags[$urandom_range(0, 3)],
                     2'($urandom_range(0, 3)));
         end else begin
            run_req(1'($urandom), idx, tags[$urandom_range(0, 2)], 1'($urandom),
                    int'($urandom_range(0, 2)));
         end
      end
   endtask

   task automatic test_reset_in_bus();
      int waitc;
      @(negedge clock);
      ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1; ifc.cpu_idx = 2'd3; ifc.cpu_tag = 8'hC7;
      ifc.bus_ready = 1'b0;
      @(posedge clock); #1;
      ifc.cpu_req = 1'b0;
      waitc = 0;
      @(negedge clock);
      while (!ifc.bus_valid && waitc < 10) begin
         @(negedge clock);
         waitc++;
      end
      checks++;
      if (ifc.bus_valid !== 1'b1) begin
         failures++;
         $display("FAIL reach_bus: bus_valid=%b required 1", ifc.bus_valid);
      end
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (ifc.bus_valid !== 1'b0 || line_state !== 8'hFF || ifc.cpu_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_bus: valid=%b lines=%b done=%b required 0 11111111 0",
                  ifc.bus_valid, line_state, ifc.cpu_done);
      end
      ifc.bus_ready = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (ifc.cpu_done !== 1'b0 || ifc.cpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_done_after_abort: done=%b ready=%b required 0 1",
                     ifc.cpu_done, ifc.cpu_ready);
         end
      end
      ifc.bus_ready = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      reset_n = 1'b0;
      ifc.cpu_req = 1'b0; ifc.cpu_we = 1'b0; ifc.cpu_idx = '0; ifc.cpu_tag = '0;
      ifc.bus_ready = 1'b0; ifc.bus_shared = 1'b0;
      ifc.snoop_valid = 1'b0; ifc.snoop_idx = '0; ifc.snoop_tag = '0; ifc.snoop_state = '0;
      model_reset();
      test_reset();
      test_directed_plan();
      test_snoop();
      test_random();
      test_reset_in_bus();
      run_req(1'b0, 2'd0, 8'h21, 1'b1, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mesi_transmissor.md
Name: mesi_transmissor

Overview:
- Local-processor side of the MESI snooping protocol. Owns per-line state and tag for a small direct-mapped cache and accepts CPU read/write requests.
- Decides hit or miss, performs local state transitions, and broadcasts bus messages (rh/rm/wh/wm) to the other caches' MESI receivers through a valid/ready handshake.
- Applies snoop-induced state updates coming from the local MESI receiver.

Parameters:
- NLINES, 4, number of cache lines (power of 2)
- IDX_W, 2, line index width = log2(NLINES)
- TAG_W, 8, tag width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_idx  in  IDX_W  line index
- cpu_tag  in  TAG_W  address tag
- cpu_ready  out  1  block idle, can accept a request
- cpu_done  out  1  one-cycle pulse, request completed
- cpu_hit  out  1  valid with cpu_done: request was a hit
- bus_valid  out  1  bus message pending
- bus_ready  in  1  bus grants/accepts the message
- bus_msg  out  2  00 rh, 01 rm, 10 wh, 11 wm
- bus_idx  out  IDX_W  index of message
- bus_tag  out  TAG_W  tag of message
- bus_wb  out  1  victim line was M: write back before fill
- bus_shared  in  1  another cache holds the line; sampled at handshake
- snoop_valid  in  1  receiver update valid
- snoop_idx  in  IDX_W  receiver update index
- snoop_tag  in  TAG_W  receiver update tag
- snoop_state  in  2  new state from receiver
- line_state  out  2*NLINES  packed current states, for debug and verification

Behaviour:
- Encodings: state 00 M, 01 E, 10 S, 11 I. Message encodings are listed under bus_msg.
- Reset (asynchronous, reset_n=0):
  - All lines set to I with tag 0; FSM goes to IDLE.
  - cpu_done, cpu_hit, bus_valid, bus_wb are 0; bus_msg, bus_idx, bus_tag are 0; cpu_ready is 1 once reset is released.
  - Reset mid-transaction aborts it with no cpu_done.
- FSM states: IDLE, EVAL, BUS, DONE.
- IDLE:
  - cpu_ready=1.
  - cpu_req=1 latches we, idx and tag, then goes to EVAL.
- EVAL (1 cycle, cpu_ready=0):
  - hit = (state[idx] != I) && (tag[idx] == req_tag).
  - Read hit in M/E/S: no bus message; state unchanged; go to DONE.
  - Write hit in M: stays M; go to DONE.
  - Write hit in E: becomes M silently; go to DONE.
  - Write hit in S: bus_msg=wh, bus_wb=0; go to BUS.
  - Read miss: bus_msg=rm; go to BUS.
  - Write miss: bus_msg=wm; go to BUS.
  - On any miss, bus_wb=1 iff the victim state[idx]==M.
- BUS:
  - bus_valid=1. bus_msg, bus_idx, bus_tag, bus_wb are held stable until bus_ready=1.
  - On the handshake edge, the line array is written and the FSM goes to DONE:
    - rm: new state = S if bus_shared else E.
    - wm and wh: new state = M.
    - tag[idx] = req_tag.
- DONE:
  - cpu_done=1 for exactly one cycle.
  - cpu_hit=1 only for EVAL hits; a wh upgrade reports cpu_hit=1.
  - Next state is IDLE.
- Array writes for hits occur on the EVAL->DONE edge.
- Latency from the accept edge: a hit has cpu_done two cycles after accept. A miss has cpu_done one cycle after the handshake; bus_valid first rises the cycle after EVAL.
- Snoop updates:
  - When snoop_valid=1, state[snoop_idx] is updated on the edge, only if tag[snoop_idx]==snoop_tag and state != I.
  - A non-matching snoop is ignored.
  - If a snoop and a local array write hit the same idx on the same edge, the local write wins.
  - A snoop during BUS to the pending idx is applied, but the DONE-entry write overwrites it.
  - A snoop during EVAL is visible to the hit decision only from the next cycle; EVAL uses the registered array.
- cpu_req while not in IDLE is ignored.
- Back-to-back operation: a request is accepted in the first IDLE cycle after DONE.

Decomposition:
- Package mesi_pkg holds:
  - state encodings (M, E, S, I);
  - message encodings (RH, RM, WH, WM);
  - FSM state enum (IDLE, EVAL, BUS, DONE).
- Sub-module mesi_line_array holds state and tag storage for NLINES lines:
  - one combinational read port;
  - a local write port with priority over the snoop write port;
  - reset to I.

Test Plan:
- Reset, then read idx 1 tag 0x3A, bus_ready=1, bus_shared=0 -> bus_msg=01, bus_wb=0; state[1]=E; cpu_done=1 with cpu_hit=0.
- Write hit to the E line (idx 1, tag 0x3A) -> no bus_valid; state[1]=M; cpu_done=1 two cycles after accept with cpu_hit=1.
- Read idx 1 tag 0x55 while line is M, bus_shared=1 -> bus_msg=01, bus_wb=1; state[1]=S; tag[1]=0x55.
- Write hit to the S line with bus_ready held 0 for 3 cycles -> bus_valid and bus_msg=10 held stable for 4 cycles; state becomes M after the handshake.
- Snoop idx 1 tag 0x55 with snoop_state=11 -> state[1]=I. Snoop with tag 0x56 -> no change. Snoop on the same edge as a local write -> local write wins.
- Assert reset_n=0 while in BUS -> bus_valid=0 immediately; all lines I; no cpu_done.
